// File: rtl/display_pkg.sv
// Shared definitions for the display scan path: blank code, state encoding and
// a small width helper used to size the scan counters.
package display_pkg;

    localparam int unsigned BCD_W      = 4;
    localparam logic [3:0]  BLANK_CODE = 4'hF;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    // Counter width for a count of n values; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scan_slot_counter.sv
// Slot sequencer for the digit scanner: walks tick within a digit slot and idx
// across the frame, and flags the blanking phase, slot end and frame wrap.
// Ports:
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_adv             advance one scan strobe (enable && strobe)
//   o_idx             current digit slot (registered)
//   o_blank_phase_c   slot is in its blanked leading portion
//   o_slot_end_c      this advance finishes the current slot
//   o_wrap_c          this advance finishes the last slot of the frame
module scan_slot_counter
    import display_pkg::*;
#(
    parameter int unsigned  NUM_DIGITS  = 6,
    parameter int unsigned  DWELL_TICKS = 8,
    parameter int unsigned  BLANK_TICKS = 1,
    localparam int unsigned IDX_W       = cnt_w(NUM_DIGITS)
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_adv,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_blank_phase_c,
    output logic             o_slot_end_c,
    output logic             o_wrap_c
);

    localparam int unsigned TICK_W = cnt_w(DWELL_TICKS);
    localparam bit          HAS_BLANK = (BLANK_TICKS > 0);

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(DWELL_TICKS - 1);
    localparam logic [TICK_W-1:0] BLANK_LAST = TICK_W'(HAS_BLANK ? BLANK_TICKS - 1 : 0);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_e       state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              drive_c;

    // Without a blanking phase the BLANK state behaves exactly like DRIVE.
    assign drive_c         = (state_q == ST_DRIVE) || !HAS_BLANK;
    assign o_blank_phase_c = !drive_c;
    assign o_slot_end_c    = i_adv && drive_c && (tick_q == TICK_LAST);
    assign o_wrap_c        = o_slot_end_c && (idx_q == IDX_LAST);
    assign o_idx           = idx_q;

    // State and counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_BLANK;
            tick_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state: tick runs across the whole slot, blank portion first.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        idx_d   = idx_q;
        if (i_adv) begin
            if (!drive_c) begin
                tick_d = tick_q + 1'b1;
                if (tick_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                end
            end else if (tick_q == TICK_LAST) begin
                tick_d  = '0;
                idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                state_d = HAS_BLANK ? ST_BLANK : ST_DRIVE;
            end else begin
                tick_d  = tick_q + 1'b1;
                state_d = ST_DRIVE;
            end
        end
    end

endmodule

// File: rtl/display_digit_scanner.sv
// Time-multiplexes a double-buffered frame of BCD digits onto a single BCD bus
// plus a one-hot digit select, with a blanking gap at the start of each slot.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros of the
// frame as it is promoted from shadow to active (digit 0 is always shown).
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_en            scan enable; low freezes the scan and blanks the outputs
//   i_scan_stb      one-cycle scan tick
//   i_load          one-cycle pulse capturing i_digits into the shadow frame
//   i_digits        packed BCD frame, digit 0 (rightmost) in bits [3:0]
//   o_bcd           BCD code to the 7-segment decoder, 4'hF = blank
//   o_digit_sel     one-hot active-high digit enable
//   o_frame_stb     one-cycle pulse when the scan wraps to digit 0
module display_digit_scanner
    import display_pkg::*;
#(
    parameter int unsigned  NUM_DIGITS  = 6,
    parameter int unsigned  DWELL_TICKS = 8,
    parameter int unsigned  BLANK_TICKS = 1,
    localparam int unsigned FRAME_W     = BCD_W * NUM_DIGITS
)(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_scan_stb,
    input  logic                  i_load,
    input  logic [FRAME_W-1:0]    i_digits,
    output logic [3:0]            o_bcd,
    output logic [NUM_DIGITS-1:0] o_digit_sel,
    output logic                  o_frame_stb
);

    localparam int unsigned IDX_W = cnt_w(NUM_DIGITS);

    typedef logic [NUM_DIGITS-1:0][BCD_W-1:0] frame_t;

    frame_t           shadow_q, active_q;
    frame_t           load_frame_c, copy_frame_c;
    logic             adv_c;
    logic [IDX_W-1:0] idx;
    logic             blank_phase_c;
    logic             slot_end_c;
    logic             wrap_c;

    assign adv_c = i_en && i_scan_stb;

    scan_slot_counter #(
        .NUM_DIGITS  (NUM_DIGITS),
        .DWELL_TICKS (DWELL_TICKS),
        .BLANK_TICKS (BLANK_TICKS)
    ) u_slot_counter (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_adv           (adv_c),
        .o_idx           (idx),
        .o_blank_phase_c (blank_phase_c),
        .o_slot_end_c    (slot_end_c),
        .o_wrap_c        (wrap_c)
    );

    // A load in the wrap cycle must reach the active frame directly.
    assign load_frame_c = i_load ? frame_t'(i_digits) : shadow_q;

`ifdef LEADING_ZERO_BLANK_EN
    // Blank every zero above the most-significant nonzero digit.
    function automatic frame_t blank_leading_zeros(input frame_t f);
        frame_t r;
        logic   leading;
        r       = f;
        leading = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
            if (leading && (f[i] == 4'h0)) begin
                r[i] = BLANK_CODE;
            end else begin
                leading = 1'b0;
            end
        end
        return r;
    endfunction

    assign copy_frame_c = blank_leading_zeros(load_frame_c);
`else
    assign copy_frame_c = load_frame_c;
`endif

    // Shadow and active frame buffers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shadow_q <= {NUM_DIGITS{BLANK_CODE}};
            active_q <= {NUM_DIGITS{BLANK_CODE}};
        end else begin
            shadow_q <= load_frame_c;
            if (wrap_c) begin
                active_q <= copy_frame_c;
            end
        end
    end

    // Output registers; the current slot's phase decides what is shown.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_bcd       <= BLANK_CODE;
            o_digit_sel <= '0;
            o_frame_stb <= 1'b0;
        end else begin
            o_frame_stb <= wrap_c;
            if (!i_en) begin
                o_bcd       <= BLANK_CODE;
                o_digit_sel <= '0;
            end else if (adv_c) begin
                if (blank_phase_c) begin
                    o_bcd       <= BLANK_CODE;
                    o_digit_sel <= '0;
                end else begin
                    o_bcd       <= active_q[idx];
                    o_digit_sel <= NUM_DIGITS'(1) << idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_display_digit_scanner.sv
// Directed bench for display_digit_scanner: table of frames, then hand-written
// mid-frame load, enable drop, load-at-wrap and async reset sequences.
module tb_display_digit_scanner;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_en;
    logic        i_scan_stb;
    logic        i_load;
    logic [23:0] i_digits;
    logic [3:0]  o_bcd;
    logic [5:0]  o_digit_sel;
    logic        o_frame_stb;

    int checks   = 0;
    int failures = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [23:0] SHOW_000000 = 24'hFFFFF0;
    localparam logic [23:0] SHOW_00FA07 = 24'hFFFA07;
    localparam logic [23:0] SHOW_000042 = 24'hFFFF42;
`else
    localparam logic [23:0] SHOW_000000 = 24'h000000;
    localparam logic [23:0] SHOW_00FA07 = 24'h00FA07;
    localparam logic [23:0] SHOW_000042 = 24'h000042;
`endif

    typedef struct {
        bit          do_load;
        logic [23:0] data;
        logic [23:0] shown;
    } frame_vec_t;

    frame_vec_t vecs [8];

    display_digit_scanner dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_en        (i_en),
        .i_scan_stb  (i_scan_stb),
        .i_load      (i_load),
        .i_digits    (i_digits),
        .o_bcd       (o_bcd),
        .o_digit_sel (o_digit_sel),
        .o_frame_stb (o_frame_stb)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Compare {frame_stb, digit_sel, bcd} against the expected triple.
    task automatic chk(input string name, input logic fs, input logic [5:0] sel, input logic [3:0] bcd);
        logic [10:0] act;
        logic [10:0] exp;
        act = {o_frame_stb, o_digit_sel, o_bcd};
        exp = {fs, sel, bcd};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got fstb=%b sel=%b bcd=%h, expected fstb=%b sel=%b bcd=%h",
                     name, act[10], act[9:4], act[3:0], exp[10], exp[9:4], exp[3:0]);
        end
    endtask

    // One scan strobe issued at a falling edge; returns at the next falling edge.
    task automatic strobe(input bit load, input logic [23:0] data);
        i_scan_stb = 1'b1;
        i_load     = load;
        if (load) i_digits = data;
        @(negedge i_clk);
        i_scan_stb = 1'b0;
        i_load     = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge i_clk);
    endtask

    task automatic load_now(input logic [23:0] data);
        i_load   = 1'b1;
        i_digits = data;
        @(negedge i_clk);
        i_load   = 1'b0;
    endtask

    // Full slot d: one blank strobe, seven drive strobes; optional load on the last.
    task automatic run_slot(input string tag, input int d, input logic [23:0] shown,
                            input bit last, input bit ld_last, input logic [23:0] ld_data);
        logic [5:0] sel;
        logic [3:0] dig;
        sel = 6'(1) << d;
        dig = shown[d*4 +: 4];
        strobe(1'b0, 24'h0);
        chk($sformatf("%s d%0d blank", tag, d), 1'b0, 6'b0, 4'hF);
        idle_cycle();
        for (int s = 1; s < 8; s++) begin
            strobe(ld_last && (s == 7), ld_data);
            chk($sformatf("%s d%0d s%0d", tag, d, s), last && (s == 7), sel, dig);
            idle_cycle();
        end
        chk($sformatf("%s d%0d hold", tag, d), 1'b0, sel, dig);
    endtask

    task automatic run_frame(input string tag, input logic [23:0] shown);
        for (int d = 0; d < 6; d++) begin
            run_slot(tag, d, shown, d == 5, 1'b0, 24'h0);
        end
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_en       = 1'b1;
        i_scan_stb = 1'b0;
        i_load     = 1'b0;
        i_digits   = 24'h123456;

        vecs[0] = '{1'b0, 24'h000000, 24'hFFFFFF};
        vecs[1] = '{1'b0, 24'h000000, 24'hFFFFFF};
        vecs[2] = '{1'b1, 24'h123456, 24'hFFFFFF};
        vecs[3] = '{1'b0, 24'h000000, 24'h123456};
        vecs[4] = '{1'b1, 24'h000000, 24'h123456};
        vecs[5] = '{1'b0, 24'h000000, SHOW_000000};
        vecs[6] = '{1'b1, 24'h00FA07, SHOW_000000};
        vecs[7] = '{1'b0, 24'h000000, SHOW_00FA07};

        @(negedge i_clk);
        chk("in_reset", 1'b0, 6'b0, 4'hF);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("after_reset", 1'b0, 6'b0, 4'hF);

        // Frame table: optional load at frame start, then a full scanned frame.
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].do_load) load_now(vecs[v].data);
            run_frame($sformatf("vec%0d", v), vecs[v].shown);
        end

        // Mid-frame load at idx 3: remainder of frame keeps old digits.
        for (int d = 0; d < 3; d++) run_slot("midload", d, SHOW_00FA07, 1'b0, 1'b0, 24'h0);
        load_now(24'h999999);
        for (int d = 3; d < 6; d++) run_slot("midload", d, SHOW_00FA07, d == 5, 1'b0, 24'h0);

        // Enable drop for 20 strobes in the middle of digit 2's drive.
        for (int d = 0; d < 2; d++) run_slot("endrop", d, 24'h999999, 1'b0, 1'b0, 24'h0);
        strobe(1'b0, 24'h0);
        chk("endrop d2 blank", 1'b0, 6'b0, 4'hF);
        idle_cycle();
        for (int s = 0; s < 3; s++) begin
            strobe(1'b0, 24'h0);
            chk($sformatf("endrop d2 pre%0d", s), 1'b0, 6'b000100, 4'h9);
            idle_cycle();
        end
        i_en = 1'b0;
        @(negedge i_clk);
        chk("endrop off_now", 1'b0, 6'b0, 4'hF);
        for (int s = 0; s < 20; s++) begin
            strobe(1'b0, 24'h0);
            chk($sformatf("endrop off%0d", s), 1'b0, 6'b0, 4'hF);
        end
        i_en = 1'b1;
        @(negedge i_clk);
        chk("endrop reen_hold", 1'b0, 6'b0, 4'hF);
        for (int s = 0; s < 4; s++) begin
            strobe(1'b0, 24'h0);
            chk($sformatf("endrop d2 post%0d", s), 1'b0, 6'b000100, 4'h9);
            idle_cycle();
        end
        run_slot("endrop", 3, 24'h999999, 1'b0, 1'b0, 24'h0);
        run_slot("endrop", 4, 24'h999999, 1'b0, 1'b0, 24'h0);
        // Load lands on the wrap strobe itself.
        run_slot("wrapload", 5, 24'h999999, 1'b1, 1'b1, 24'h000042);
        run_frame("wrapload", SHOW_000042);

        // Asynchronous reset between edges while driving digit 0.
        strobe(1'b0, 24'h0);
        chk("areset blank", 1'b0, 6'b0, 4'hF);
        idle_cycle();
        for (int s = 0; s < 2; s++) begin
            strobe(1'b0, 24'h0);
            chk($sformatf("areset drv%0d", s), 1'b0, 6'b000001, SHOW_000042[3:0]);
            idle_cycle();
        end
        #2 i_rst_n = 1'b0;
        #1 chk("areset immediate", 1'b0, 6'b0, 4'hF);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("areset released", 1'b0, 6'b0, 4'hF);
        run_frame("postreset", 24'hFFFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
